// File: rtl/i2c_read_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_read_sequencer
//
// Sequences one I2C read transaction over external bus-condition, byte-
// transmit and byte-receive engines: START, address byte with R/W=1,
// len data bytes (NACK on the last), STOP. Every wait on an engine is
// bounded by TIMEOUT_CYCLES; the outcome is reported through o_done/o_err.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_cmd_valid/_addr/_len  read command (len 0 = address probe)
//   o_cmd_ready             command accepted only while idle
//   o_start_req/o_stop_req  one-cycle requests to the condition generator
//   i_cond_done             start/stop condition finished
//   o_tx_start, o_tx_data   address byte request to the transmitter
//   i_tx_done, i_tx_nack    byte sent / slave NACKed it
//   o_rx_start, o_send_nack byte request and ACK/NACK choice for receiver
//   i_rx_done, i_rx_data    received byte
//   o_data, o_data_valid    received byte stream (no backpressure)
//   o_busy, o_done, o_err   status; o_err 00 ok, 01 NACK, 10 timeout
// ---------------------------------------------------------------------------
module i2c_read_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    input  logic [6:0] i_cmd_addr,
    input  logic [7:0] i_cmd_len,
    output logic       o_cmd_ready,
    output logic       o_start_req,
    output logic       o_stop_req,
    input  logic       i_cond_done,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_done,
    input  logic       i_tx_nack,
    output logic       o_rx_start,
    output logic       o_send_nack,
    input  logic       i_rx_done,
    input  logic [7:0] i_rx_data,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        RX    = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic [1:0]  ERR_NONE    = 2'b00;
    localparam logic [1:0]  ERR_NACK    = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b10;

    state_t      state_q;
    logic [6:0]  addr_q;
    logic [7:0]  rem_q;
    logic [15:0] wait_q;
    logic        start_q;
    logic        stop_q;
    logic        tx_start_q;
    logic        rx_start_q;
    logic [7:0]  data_q;
    logic        data_valid_q;
    logic        done_q;
    logic [1:0]  err_q;

    logic timed_out;
    assign timed_out = (wait_q == TIMEOUT_LIM);

    // The first recorded error is the one reported.
    function automatic logic [1:0] first_err(input logic [1:0] cur, input logic [1:0] nxt);
        return (cur == ERR_NONE) ? nxt : cur;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            wait_q       <= '0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            tx_start_q   <= 1'b0;
            rx_start_q   <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= ERR_NONE;
        end else begin
            // Pulses last one cycle; the wait counter runs unless a state
            // entry below restarts it.
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            tx_start_q   <= 1'b0;
            rx_start_q   <= 1'b0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            wait_q       <= wait_q + 16'd1;

            case (state_q)
                IDLE: begin
                    wait_q <= '0;
                    if (i_cmd_valid) begin
                        addr_q  <= i_cmd_addr;
                        rem_q   <= i_cmd_len;
                        err_q   <= ERR_NONE;
                        state_q <= START;
                        start_q <= 1'b1;
                    end
                end

                START: begin
                    if (i_cond_done) begin
                        state_q    <= ADDR;
                        tx_start_q <= 1'b1;
                        wait_q     <= '0;
                    end else if (timed_out) begin
                        err_q   <= first_err(err_q, ERR_TIMEOUT);
                        state_q <= STOP;
                        stop_q  <= 1'b1;
                        wait_q  <= '0;
                    end
                end

                ADDR: begin
                    if (i_tx_done) begin
                        wait_q <= '0;
                        if (i_tx_nack) begin
                            err_q   <= first_err(err_q, ERR_NACK);
                            state_q <= STOP;
                            stop_q  <= 1'b1;
                        end else if (rem_q == 8'd0) begin
                            state_q <= STOP;
                            stop_q  <= 1'b1;
                        end else begin
                            state_q    <= RX;
                            rx_start_q <= 1'b1;
                        end
                    end else if (timed_out) begin
                        err_q   <= first_err(err_q, ERR_TIMEOUT);
                        state_q <= STOP;
                        stop_q  <= 1'b1;
                        wait_q  <= '0;
                    end
                end

                RX: begin
                    if (i_rx_done) begin
                        data_q       <= i_rx_data;
                        data_valid_q <= 1'b1;
                        rem_q        <= rem_q - 8'd1;  // rem_q >= 1 whenever in RX
                        wait_q       <= '0;
                        if (rem_q == 8'd1) begin
                            state_q <= STOP;
                            stop_q  <= 1'b1;
                        end else begin
                            rx_start_q <= 1'b1;      // re-enter RX for next byte
                        end
                    end else if (timed_out) begin
                        err_q   <= first_err(err_q, ERR_TIMEOUT);
                        state_q <= STOP;
                        stop_q  <= 1'b1;
                        wait_q  <= '0;
                    end
                end

                STOP: begin
                    if (i_cond_done) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        wait_q  <= '0;
                    end else if (timed_out) begin
                        err_q   <= first_err(err_q, ERR_TIMEOUT);
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        wait_q  <= '0;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    wait_q  <= '0;
                end

                default: begin
                    state_q <= IDLE;
                    wait_q  <= '0;
                end
            endcase
        end
    end

    assign o_cmd_ready  = (state_q == IDLE);
    assign o_busy       = (state_q != IDLE);
    assign o_start_req  = start_q;
    assign o_stop_req   = stop_q;
    assign o_tx_start   = tx_start_q;
    assign o_rx_start   = rx_start_q;
    // Address byte and NACK choice are pure decodes of held registers, so
    // they stay stable for the whole state.
    assign o_tx_data    = (state_q == ADDR) ? {addr_q, 1'b1} : 8'h00;
    assign o_send_nack  = (state_q == RX) && (rem_q == 8'd1);
    assign o_data       = data_q;
    assign o_data_valid = data_valid_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_i2c_read_sequencer.sv
module tb_i2c_read_sequencer;

    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_cmd_valid = 1'b0;
    logic [6:0] i_cmd_addr = '0;
    logic [7:0] i_cmd_len = '0;
    logic       o_cmd_ready, o_start_req, o_stop_req;
    logic       i_cond_done = 1'b0;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       i_tx_done = 1'b0, i_tx_nack = 1'b0;
    logic       o_rx_start, o_send_nack;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_rx_data = '0;
    logic [7:0] o_data;
    logic       o_data_valid, o_busy, o_done;
    logic [1:0] o_err;

    i2c_read_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(i_cmd_valid), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
        .o_cmd_ready(o_cmd_ready), .o_start_req(o_start_req), .o_stop_req(o_stop_req),
        .i_cond_done(i_cond_done), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_tx_done(i_tx_done), .i_tx_nack(i_tx_nack), .o_rx_start(o_rx_start),
        .o_send_nack(o_send_nack), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .o_data(o_data), .o_data_valid(o_data_valid), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference-model state
    logic [7:0] exp_tx;
    logic       exp_snack;
    logic       pend_dv;
    logic [7:0] pend_data;
    logic [7:0] last_data;
    logic [1:0] last_err;
    bit         use_dir;
    logic [7:0] dir_bytes [0:1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle_inputs();
        i_cmd_valid = 1'b0;
        i_cond_done = 1'b0;
        i_tx_done   = 1'b0;
        i_tx_nack   = 1'b0;
        i_rx_done   = 1'b0;
    endtask

    // Delay (cycles after the request pulse) before the responder answers;
    // -1 means it never answers.
    function automatic int pick_delay(input int ph, input bit rnd, input int to_ph, input int bnd_ph);
        int r;
        if (ph == to_ph)  return -1;
        if (ph == bnd_ph) return TO;
        if (!rnd)         return 1;
        r = int'($urandom_range(0, 15));
        if (r == 0) return -1;
        if (r == 1) return TO;
        return int'($urandom_range(0, 3));
    endfunction

    // Called at the falling edge of the first cycle of a waiting state.
    // kind: 0 condition, 1 tx, 2 rx. pulse_id: 0 start, 1 stop, 2 tx, 3 rx.
    // Leaves the bench at the falling edge of the first cycle of the next state.
    task automatic wait_phase(input int kind, input int pulse_id, input int d,
                              input logic nack_in, input logic [7:0] byte_in);
        int last;
        logic [3:0] ep;
        last = (d < 0) ? TO : d;
        for (int k = 0; k <= last; k++) begin
            ep = 4'b0000;
            if (k == 0) ep[3 - pulse_id] = 1'b1;
            check_val("pulses", {o_start_req, o_stop_req, o_tx_start, o_rx_start}, ep);
            check_val("busy_ready_done", {o_busy, o_cmd_ready, o_done}, 3'b100);
            check_val("tx_data", o_tx_data, exp_tx);
            check_val("send_nack", o_send_nack, exp_snack);
            check_val("data_valid", o_data_valid, (k == 0) && pend_dv);
            if (k == 0 && pend_dv) check_val("data", o_data, pend_data);
            pend_dv = 1'b0;
            // Awaited input on cycle d; unrelated done inputs and commands
            // are sprinkled in randomly and must be ignored.
            i_cond_done = (kind == 0) ? (k == d) : ($urandom_range(0, 7) == 0);
            i_tx_done   = (kind == 1) ? (k == d) : ($urandom_range(0, 7) == 0);
            i_tx_nack   = (kind == 1) ? nack_in : logic'($urandom_range(0, 1));
            i_rx_done   = (kind == 2) ? (k == d) : ($urandom_range(0, 7) == 0);
            i_rx_data   = (kind == 2 && k == d) ? byte_in : 8'($urandom);
            i_cmd_valid = ($urandom_range(0, 3) == 0);
            i_cmd_addr  = 7'($urandom);
            i_cmd_len   = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic run_txn(input logic [6:0] addr, input logic [7:0] len, input logic nack,
                           input bit rnd, input int to_ph, input int bnd_ph);
        logic [1:0] err;
        int d, rem, idx;
        logic [7:0] b;
        err = 2'b00;
        exp_tx = 8'h00;
        exp_snack = 1'b0;
        check_val("ready_before_cmd", o_cmd_ready, 1'b1);
        i_cmd_valid = 1'b1;
        i_cmd_addr  = addr;
        i_cmd_len   = len;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        d = pick_delay(0, rnd, to_ph, bnd_ph);
        wait_phase(0, 0, d, 1'b0, 8'h00);
        if (d < 0) begin
            err = 2'b10;
        end else begin
            exp_tx = {addr, 1'b1};
            d = pick_delay(1, rnd, to_ph, bnd_ph);
            wait_phase(1, 2, d, nack, 8'h00);
            exp_tx = 8'h00;
            if (d < 0) err = 2'b10;
            else if (nack) err = 2'b01;
            else begin
                rem = int'(len);
                idx = 0;
                while (rem > 0) begin
                    exp_snack = (rem == 1);
                    b = (use_dir && idx < 2) ? dir_bytes[idx] : 8'($urandom);
                    d = pick_delay(2, rnd, to_ph, bnd_ph);
                    wait_phase(2, 3, d, 1'b0, b);
                    exp_snack = 1'b0;
                    if (d < 0) begin
                        err = 2'b10;
                        break;
                    end
                    pend_dv   = 1'b1;
                    pend_data = b;
                    last_data = b;
                    rem--;
                    idx++;
                end
            end
        end
        d = pick_delay(3, rnd, to_ph, bnd_ph);
        wait_phase(0, 1, d, 1'b0, 8'h00);
        if (d < 0 && err == 2'b00) err = 2'b10;
        drive_idle_inputs();
        // DONE cycle
        check_val("done_pulse", {o_done, o_busy, o_cmd_ready}, 3'b110);
        check_val("err_at_done", o_err, err);
        check_val("done_quiet", {o_start_req, o_stop_req, o_tx_start, o_rx_start, o_data_valid}, 5'b0);
        @(negedge clk);
        // Back in IDLE
        check_val("idle_status", {o_done, o_busy, o_cmd_ready}, 3'b001);
        check_val("err_held", o_err, err);
        check_val("data_held", o_data, last_data);
        last_err = err;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val(tag, {o_start_req, o_stop_req, o_tx_start, o_rx_start, o_data_valid,
                        o_done, o_busy, o_send_nack, o_cmd_ready}, 9'b000000001);
        check_val({tag, "_data"}, {o_data, o_tx_data, 6'b0, o_err}, 24'h0);
    endtask

    initial begin
        #1_000_000;
        $display("watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        int len_r;
        pend_dv = 1'b0;
        pend_data = 8'h00;
        last_data = 8'h00;
        last_err = 2'b00;
        use_dir = 1'b0;
        exp_tx = 8'h00;
        exp_snack = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two-byte read, all ACK
        use_dir = 1'b1;
        dir_bytes[0] = 8'hA5;
        dir_bytes[1] = 8'h3C;
        run_txn(7'h50, 8'd2, 1'b0, 1'b0, -1, -1);
        use_dir = 1'b0;
        // Address NACK: no RX, error 01
        run_txn(7'h21, 8'd1, 1'b1, 1'b0, -1, -1);
        // Address probe
        run_txn(7'h21, 8'd0, 1'b0, 1'b0, -1, -1);
        // Receiver never answers
        run_txn(7'h33, 8'd2, 1'b0, 1'b0, 2, -1);
        // Done arriving on the timeout edge wins
        run_txn(7'h12, 8'd1, 1'b0, 1'b0, -1, 1);
        run_txn(7'h13, 8'd2, 1'b0, 1'b0, -1, 2);
        // NACK followed by stop timeout keeps error 01
        run_txn(7'h05, 8'd3, 1'b1, 1'b0, 3, -1);
        // Start condition timeout
        run_txn(7'h06, 8'd3, 1'b0, 1'b0, 0, -1);

        // Stray receive done while idle changes nothing
        i_rx_done = 1'b1;
        i_rx_data = 8'h77;
        @(negedge clk);
        i_rx_done = 1'b0;
        check_val("stray_rx_valid", o_data_valid, 1'b0);
        check_val("stray_rx_data", o_data, last_data);
        check_val("stray_rx_status", {o_busy, o_cmd_ready, o_err}, {2'b01, last_err});

        // Reset in the middle of RX
        i_cmd_valid = 1'b1;
        i_cmd_addr  = 7'h10;
        i_cmd_len   = 8'd3;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        exp_tx = 8'h00;
        wait_phase(0, 0, 0, 1'b0, 8'h00);
        exp_tx = {7'h10, 1'b1};
        wait_phase(1, 2, 0, 1'b0, 8'h00);
        exp_tx = 8'h00;
        drive_idle_inputs();
        check_val("rx_entered", {o_rx_start, o_busy}, 2'b11);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_rx");
        @(negedge clk);
        check_reset_outputs("reset_held");
        rst = 1'b0;
        last_data = 8'h00;
        pend_dv = 1'b0;
        @(negedge clk);
        run_txn(7'h44, 8'd2, 1'b0, 1'b0, -1, -1);

        // Maximum length read
        run_txn(7'h7F, 8'd255, 1'b0, 1'b0, -1, -1);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            len_r = int'($urandom_range(0, 9));
            run_txn(7'($urandom),
                    (len_r < 2) ? 8'd0 : (len_r < 9) ? 8'($urandom_range(1, 4)) : 8'($urandom_range(5, 20)),
                    ($urandom_range(0, 4) == 0), 1'b1, -1, -1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
